// File: rtl/arm_pipelined_stage_buffer.sv
// rtl/arm_pipelined_stage_buffer.sv - valid/ready pipeline stage with 2-entry skid buffer; optional stall counter under ARM_PIPE_STAGE_STATS_EN
module arm_pipelined_stage_buffer #(
  parameter int                  BusWidth   = 32,
  parameter logic [BusWidth-1:0] ResetValue = '0,
  parameter int                  CntWidth   = 16
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_FLUSH,
  input  logic                i_VALID,
  output logic                o_READY,
  input  logic [BusWidth-1:0] i_DATA,
  output logic                o_VALID,
  input  logic                i_READY,
  output logic [BusWidth-1:0] o_DATA,
  output logic [1:0]          o_COUNT
`ifdef ARM_PIPE_STAGE_STATS_EN
  ,
  output logic [CntWidth-1:0] o_STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BusWidth-1:0] main_q;
  logic [BusWidth-1:0] skid_q;
  logic                in_fire;
  logic                out_fire;

  assign in_fire  = i_VALID & o_READY;
  assign out_fire = o_VALID & i_READY;
  assign o_DATA   = main_q;

  // State register; flush is folded into state_nxt so it only needs reset here.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: flush squashes to EMPTY, otherwise follow the handshakes.
  always_comb begin
    state_nxt = state;
    if (i_FLUSH) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_nxt = BUSY;
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_nxt = FULL;
          end else if (!in_fire && out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_fire) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs decoded directly from the current state.
  always_comb begin
    o_VALID = (state != EMPTY);
    case (state)
      BUSY:    o_COUNT = 2'd1;
      FULL:    o_COUNT = 2'd2;
      default: o_COUNT = 2'd0;
    endcase
  end

  // Registered ready: looks ahead at state_nxt so upstream never sees a comb path from i_READY.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      o_READY <= 1'b1;
    end else begin
      o_READY <= (state_nxt != FULL);
    end
  end

  // Payload storage: main feeds o_DATA, skid catches the entry that arrives while main is stalled.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      main_q <= ResetValue;
      skid_q <= ResetValue;
    end else if (i_FLUSH) begin
      main_q <= ResetValue;
      skid_q <= ResetValue;
    end else begin
      case (state)
        EMPTY: if (in_fire) main_q <= i_DATA;
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= i_DATA;
          end else if (in_fire) begin
            skid_q <= i_DATA;
          end
        end
        FULL: if (out_fire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef ARM_PIPE_STAGE_STATS_EN
  logic [CntWidth-1:0] stall_cnt_q;

  assign o_STALL_CNT = stall_cnt_q;

  // Saturating count of cycles where valid data waits on a stalled downstream.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      stall_cnt_q <= '0;
    end else if (i_FLUSH) begin
      stall_cnt_q <= '0;
    end else if (o_VALID && !i_READY && (stall_cnt_q != {CntWidth{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
`else
  logic [CntWidth-1:0] unused_stall_cnt;
  assign unused_stall_cnt = '0;
`endif

endmodule
